// File: rtl/watch_tx_report.sv
// Stopwatch report formatter: on request, snapshots the watch time and streams
// "HH:MM:SS.CC\r\n" one byte at a time to a UART transmitter.
module watch_tx_report #(
  parameter int MSEC_MAX = 100,
  parameter int SEC_MAX  = 60,
  parameter int MIN_MAX  = 60,
  parameter int HOUR_MAX = 24
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        i_req,
  input  logic [$clog2(MSEC_MAX)-1:0] msec,
  input  logic [$clog2(SEC_MAX)-1:0]  sec,
  input  logic [$clog2(MIN_MAX)-1:0]  min,
  input  logic [$clog2(HOUR_MAX)-1:0] hour,
  input  logic                        tx_busy,
  input  logic                        tx_done,
  output logic [7:0]                  tx_data,
  output logic                        tx_start,
  output logic                        o_busy
);

  localparam int MSW = $clog2(MSEC_MAX);
  localparam int SW  = $clog2(SEC_MAX);
  localparam int MW  = $clog2(MIN_MAX);
  localparam int HW  = $clog2(HOUR_MAX);
  localparam logic [3:0] LAST_IDX = 4'd12;

  typedef enum logic [1:0] {IDLE, SEND, WAIT} state_t;

  state_t         state;
  logic [3:0]     index;
  logic [MSW-1:0] snap_msec;
  logic [SW-1:0]  snap_sec;
  logic [MW-1:0]  snap_min;
  logic [HW-1:0]  snap_hour;
  logic [7:0]     next_byte;
  logic [7:0]     h8, m8, s8, c8;

  function automatic logic [7:0] tens_ascii(input logic [7:0] v);
    return 8'h30 + v / 8'd10;
  endfunction

  function automatic logic [7:0] ones_ascii(input logic [7:0] v);
    return 8'h30 + v % 8'd10;
  endfunction

  // Byte selector: the frame is built only from the snapshot registers.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    next_byte = 8'h00;
    h8 = 8'(snap_hour);
    m8 = 8'(snap_min);
    s8 = 8'(snap_sec);
    c8 = 8'(snap_msec);
    case (index)
      4'd0:    next_byte = tens_ascii(h8);
      4'd1:    next_byte = ones_ascii(h8);
      4'd2:    next_byte = 8'h3A;
      4'd3:    next_byte = tens_ascii(m8);
      4'd4:    next_byte = ones_ascii(m8);
      4'd5:    next_byte = 8'h3A;
      4'd6:    next_byte = tens_ascii(s8);
      4'd7:    next_byte = ones_ascii(s8);
      4'd8:    next_byte = 8'h2E;
      4'd9:    next_byte = tens_ascii(c8);
      4'd10:   next_byte = ones_ascii(c8);
      4'd11:   next_byte = 8'h0D;
      4'd12:   next_byte = 8'h0A;
      default: next_byte = 8'h00;
    endcase
  end

  // NOTE: all state here is sequential, so it uses non-blocking assignments only.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      index     <= 4'd0;
      snap_msec <= '0;
      snap_sec  <= '0;
      snap_min  <= '0;
      snap_hour <= '0;
      tx_data   <= 8'h00;
      tx_start  <= 1'b0;
      o_busy    <= 1'b0;
    end else begin
      tx_start <= 1'b0;
      case (state)
        IDLE: begin
          if (i_req) begin
            snap_msec <= msec;
            snap_sec  <= sec;
            snap_min  <= min;
            snap_hour <= hour;
            index     <= 4'd0;
            state     <= SEND;
            o_busy    <= 1'b1;
          end
        end
        SEND: begin
          if (!tx_busy) begin
            tx_data  <= next_byte;
            tx_start <= 1'b1;
            state    <= WAIT;
          end
        end
        WAIT: begin
          if (tx_done) begin
            if (index == LAST_IDX) begin
              state  <= IDLE;
              o_busy <= 1'b0;
            end else begin
              index <= index + 4'd1;
              state <= SEND;
            end
          end
        end
        default: begin
          state  <= IDLE;
          o_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_watch_tx_report.sv
// Self-checking bench for watch_tx_report: transmitter model plus a byte scoreboard.
module tb_watch_tx_report;

  logic       clk;
  logic       reset;
  logic       i_req;
  logic [6:0] msec;
  logic [5:0] sec;
  logic [5:0] min;
  logic [4:0] hour;
  logic       tx_busy;
  logic       tx_done;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       o_busy;

  int checks   = 0;
  int failures = 0;

  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  int   pulse_cnt    = 0;
  int   done_cnt     = 0;
  bit   double_pulse = 0;
  bit   prev_start   = 0;
  bit   hold_busy    = 0;
  bit   model_busy   = 0;
  int   model_cnt    = 0;

  watch_tx_report dut (
    .clk      (clk),
    .reset    (reset),
    .i_req    (i_req),
    .msec     (msec),
    .sec      (sec),
    .min      (min),
    .hour     (hour),
    .tx_busy  (tx_busy),
    .tx_done  (tx_done),
    .tx_data  (tx_data),
    .tx_start (tx_start),
    .o_busy   (o_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Transmitter model: tx_done pulses 10 cycles after each tx_start.
  initial begin
    tx_busy = 1'b0;
    tx_done = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      tx_done = 1'b0;
      if (model_cnt > 0) begin
        model_cnt--;
        if (model_cnt == 0) begin
          tx_done    = 1'b1;
          model_busy = 1'b0;
          done_cnt++;
        end
      end
      if (tx_start) begin
        model_cnt  = 10;
        model_busy = 1'b1;
      end
      tx_busy = model_busy | hold_busy;
    end
  end

  // Monitor: record every transmitted byte away from the active edge.
  always @(negedge clk) begin
    if (tx_start) begin
      got_q.push_back(tx_data);
      pulse_cnt++;
      if (prev_start) double_pulse = 1;
    end
    prev_start = tx_start;
  end

  task automatic push_expected(input int hh, input int mm, input int ss, input int cc);
    string txt;
    txt = $sformatf("%02d:%02d:%02d.%02d", hh, mm, ss, cc);
    for (int i = 0; i < 11; i++) exp_q.push_back(8'(txt[i]));
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
  endtask

  task automatic start_frame(input int hh, input int mm, input int ss, input int cc);
    @(posedge clk);
    #1;
    hour = 5'(hh); min = 6'(mm); sec = 6'(ss); msec = 7'(cc);
    got_q.delete();
    exp_q.delete();
    done_cnt     = 0;
    double_pulse = 0;
    push_expected(hh, mm, ss, cc);
    i_req = 1'b1;
    @(posedge clk);
    #1;
    i_req = 1'b0;
  endtask

  task automatic wait_got(input int n, input string name);
    int k = 0;
    while (got_q.size() < n && k < 500) begin
      @(posedge clk);
      k++;
    end
    checks++;
    if (got_q.size() < n) begin
      failures++;
      $display("FAIL %s: bytes seen %0d, required at least %0d (timeout)", name, got_q.size(), n);
    end
  endtask

  task automatic finish_frame(input string name);
    int k = 0;
    logic [7:0] e, g;
    while (o_busy && k < 600) begin
      @(posedge clk);
      #1;
      k++;
    end
    checks++;
    if (o_busy !== 1'b0) begin
      failures++;
      $display("FAIL %s_busy_fall: o_busy=%b, required 0 (timeout)", name, o_busy);
    end
    checks++;
    if (got_q.size() != 13) begin
      failures++;
      $display("FAIL %s_count: tx_start pulses %0d, required 13", name, got_q.size());
    end
    checks++;
    if (done_cnt != 13) begin
      failures++;
      $display("FAIL %s_done: tx_done seen at o_busy fall %0d, required 13", name, done_cnt);
    end
    checks++;
    if (double_pulse) begin
      failures++;
      $display("FAIL %s_pulse_width: tx_start high 2+ cycles, required 1", name);
    end
    for (int i = 0; i < 13; i++) begin
      e = exp_q.size() > 0 ? exp_q.pop_front() : 8'h00;
      g = got_q.size() > 0 ? got_q.pop_front() : 8'hxx;
      checks++;
      if (g !== e) begin
        failures++;
        $display("FAIL %s_byte%0d: tx_data=%h, required %h", name, i, g, e);
      end
    end
    exp_q.delete();
    got_q.delete();
  endtask

  task automatic test_reset;
    reset = 1'b0;
    #2;
    checks++;
    if (tx_start !== 1'b0) begin failures++; $display("FAIL reset_tx_start: %b, required 0", tx_start); end
    checks++;
    if (o_busy !== 1'b0) begin failures++; $display("FAIL reset_o_busy: %b, required 0", o_busy); end
    checks++;
    if (tx_data !== 8'h00) begin failures++; $display("FAIL reset_tx_data: %h, required 00", tx_data); end
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_basic;
    start_frame(13, 5, 9, 42);
    checks++;
    if (tx_start !== 1'b0 || o_busy !== 1'b1) begin
      failures++;
      $display("FAIL latency_1clk: tx_start=%b o_busy=%b, required 0 1", tx_start, o_busy);
    end
    @(posedge clk);
    #1;
    checks++;
    if (tx_start !== 1'b1) begin
      failures++;
      $display("FAIL latency_2clk: tx_start=%b, required 1", tx_start);
    end
    finish_frame("basic");
    checks++;
    if (tx_data !== 8'h0A) begin
      failures++;
      $display("FAIL basic_hold: tx_data=%h, required 0a", tx_data);
    end
  endtask

  task automatic test_limits;
    start_frame(23, 59, 59, 99);
    finish_frame("max");
    start_frame(0, 0, 0, 0);
    finish_frame("zero");
  endtask

  task automatic test_snapshot;
    start_frame(1, 2, 3, 4);
    wait_got(3, "snap_wait");
    hour = 5'd5; min = 6'd6; sec = 6'd7; msec = 7'd8;
    finish_frame("snapshot");
  endtask

  task automatic test_back_to_back;
    start_frame(12, 34, 56, 78);
    wait_got(4, "b2b_wait");
    @(posedge clk);
    #1;
    i_req = 1'b1;
    @(posedge clk);
    #1;
    i_req = 1'b0;
    finish_frame("b2b");
    repeat (5) @(posedge clk);
    start_frame(9, 8, 7, 6);
    finish_frame("b2b_fresh");
  endtask

  task automatic test_busy_hold;
    int base;
    @(posedge clk);
    #1;
    hold_busy = 1'b1;
    tx_busy   = 1'b1;
    start_frame(4, 3, 2, 1);
    base = pulse_cnt;
    repeat (20) @(posedge clk);
    #1;
    checks++;
    if (pulse_cnt != base || tx_start !== 1'b0) begin
      failures++;
      $display("FAIL hold_no_start: pulses %0d, required 0", pulse_cnt - base);
    end
    hold_busy = 1'b0;
    tx_busy   = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (tx_start !== 1'b1) begin
      failures++;
      $display("FAIL hold_release: tx_start=%b, required 1", tx_start);
    end
    finish_frame("hold");
  endtask

  task automatic test_reset_mid;
    int base;
    start_frame(10, 20, 30, 40);
    wait_got(6, "midrst_wait");
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    checks++;
    if (tx_start !== 1'b0 || o_busy !== 1'b0 || tx_data !== 8'h00) begin
      failures++;
      $display("FAIL midrst_immediate: tx_start=%b o_busy=%b tx_data=%h, required 0 0 00",
               tx_start, o_busy, tx_data);
    end
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    base = pulse_cnt;
    repeat (40) @(posedge clk);
    #1;
    checks++;
    if (pulse_cnt != base || o_busy !== 1'b0) begin
      failures++;
      $display("FAIL midrst_quiet: pulses %0d o_busy=%b, required 0 0", pulse_cnt - base, o_busy);
    end
    start_frame(11, 22, 33, 44);
    finish_frame("after_reset");
  endtask

  initial begin
    reset = 1'b1;
    i_req = 1'b0;
    hour = '0; min = '0; sec = '0; msec = '0;
    #1;
    test_reset();
    test_basic();
    test_limits();
    test_snapshot();
    test_back_to_back();
    test_busy_hold();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
